// File: rtl/register_file.sv
// register_file
//   32 x 32-bit general-purpose register file for the single-cycle RISC-V
//   datapath: two combinational read ports (rs1/rs2 operands) and one
//   synchronous write port (rd writeback). x0 always reads as zero.
//
// Ports
//   clk        in   clock; all state updates on the rising edge
//   reset      in   synchronous, active-high; clears every register
//   reg_write  in   write enable for port D
//   addrA      in   read address, port A
//   addrB      in   read address, port B
//   addrD      in   write address, port D
//   dataD      in   write data, port D
//   dataA      out  read data, port A (combinational from addrA)
//   dataB      out  read data, port B (combinational from addrB)
module register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] addrA,
    input  logic [ADDR_WIDTH-1:0] addrB,
    input  logic [ADDR_WIDTH-1:0] addrD,
    input  logic [DATA_WIDTH-1:0] dataD,
    output logic [DATA_WIDTH-1:0] dataA,
    output logic [DATA_WIDTH-1:0] dataB
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic                  wr_en;

    // Writes aimed at x0 are dropped here, so entry 0 only ever holds a
    // reset value; the read muxes still force zero so x0 is correct even
    // before the first reset.
    assign wr_en = reg_write && (addrD != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else if (wr_en) begin
            regs_q[addrD] <= dataD;
        end
    end

    // No write-to-read bypass: reads see the stored value until the edge.
    always_comb begin
        dataA = '0;
        dataB = '0;
        if (addrA != '0) begin
            dataA = regs_q[addrA];
        end
        if (addrB != '0) begin
            dataB = regs_q[addrB];
        end
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          reg_write;
    logic [AW-1:0] addrA;
    logic [AW-1:0] addrB;
    logic [AW-1:0] addrD;
    logic [DW-1:0] dataD;
    logic [DW-1:0] dataA;
    logic [DW-1:0] dataB;

    int errors = 0;
    int checks = 0;

    // Reference model: an array of register contents, updated once per edge.
    logic [DW-1:0] model [32];

    always #5 clk = ~clk;

    register_file #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .reg_write(reg_write),
        .addrA    (addrA),
        .addrB    (addrB),
        .addrD    (addrD),
        .dataD    (dataD),
        .dataA    (dataA),
        .dataB    (dataB)
    );

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        return model[a];
    endfunction

    // Advance one rising edge, apply the architectural rules to the model
    // using the inputs present at that edge, then settle 1 time unit.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (reg_write && addrD != 0) begin
            model[addrD] = dataD;
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset     = 1'b0;
        reg_write = 1'b0;
        addrD     = '0;
        dataD     = '0;
    endtask

    task automatic test_x0_before_reset();
        idle_inputs();
        addrA = '0;
        addrB = '0;
        #1;
        checks++;
        if (dataA !== 32'h0) begin
            $display("FAIL x0_pre_reset_A: got %h want %h", dataA, 32'h0);
            errors++;
        end
        checks++;
        if (dataB !== 32'h0) begin
            $display("FAIL x0_pre_reset_B: got %h want %h", dataB, 32'h0);
            errors++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            addrA = AW'(i);
            addrB = AW'(31 - i);
            #1;
            checks++;
            if (dataA !== 32'h0 || dataB !== 32'h0) begin
                $display("FAIL reset_state[%0d]: got A=%h B=%h want 0", i, dataA, dataB);
                errors++;
            end
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] expb;
        int            nb;
        idle_inputs();
        reg_write = 1'b1;
        for (int i = 1; i < 32; i++) begin
            addrD = AW'(i);
            dataD = 32'h11111111 + DW'(i);
            tick();
        end
        idle_inputs();
        for (int i = 1; i < 32; i++) begin
            nb    = (i + 1) % 32;
            addrA = AW'(i);
            addrB = AW'(nb);
            expb  = (nb == 0) ? 32'h0 : 32'h11111111 + DW'(nb);
            #1;
            checks++;
            if (dataA !== 32'h11111111 + DW'(i)) begin
                $display("FAIL fill_A[%0d]: got %h want %h", i, dataA, 32'h11111111 + DW'(i));
                errors++;
            end
            checks++;
            if (dataB !== expb) begin
                $display("FAIL fill_B[%0d]: got %h want %h", nb, dataB, expb);
                errors++;
            end
        end
    endtask

    task automatic test_reset_clears();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        addrA = 5'd5;
        addrB = 5'd10;
        #1;
        checks++;
        if (dataA !== 32'h0 || dataB !== 32'h0) begin
            $display("FAIL reset_clears: got A=%h B=%h want 0", dataA, dataB);
            errors++;
        end
    endtask

    task automatic test_x0_protect();
        idle_inputs();
        reg_write = 1'b1;
        addrD     = '0;
        dataD     = 32'hDEADBEEF;
        tick();
        idle_inputs();
        addrA = '0;
        addrB = '0;
        #1;
        checks++;
        if (dataA !== 32'h0 || dataB !== 32'h0) begin
            $display("FAIL x0_protect: got A=%h B=%h want 0", dataA, dataB);
            errors++;
        end
    endtask

    task automatic test_write_enable();
        idle_inputs();
        reg_write = 1'b1;
        addrD     = 5'd7;
        dataD     = 32'hCAFEBABE;
        tick();
        reg_write = 1'b0;
        dataD     = 32'h12345678;
        tick();
        addrA = 5'd7;
        addrB = 5'd7;
        #1;
        checks++;
        if (dataA !== 32'hCAFEBABE || dataB !== 32'hCAFEBABE) begin
            $display("FAIL we_gating: got A=%h B=%h want %h", dataA, dataB, 32'hCAFEBABE);
            errors++;
        end
    endtask

    task automatic test_read_during_write();
        idle_inputs();
        reg_write = 1'b1;
        addrD     = 5'd3;
        dataD     = 32'hAAAA0000;
        tick();
        dataD = 32'h5555FFFF;
        addrA = 5'd3;
        #1;
        checks++;
        if (dataA !== 32'hAAAA0000) begin
            $display("FAIL rdw_before_edge: got %h want %h", dataA, 32'hAAAA0000);
            errors++;
        end
        tick();
        checks++;
        if (dataA !== 32'h5555FFFF) begin
            $display("FAIL rdw_after_edge: got %h want %h", dataA, 32'h5555FFFF);
            errors++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_priority();
        idle_inputs();
        reset     = 1'b1;
        reg_write = 1'b1;
        addrD     = 5'd3;
        dataD     = 32'h5555FFFF;
        addrA     = 5'd3;
        addrB     = 5'd7;
        #1;
        checks++;
        if (dataA !== 32'h5555FFFF) begin
            $display("FAIL rst_prio_before_edge: got %h want %h", dataA, 32'h5555FFFF);
            errors++;
        end
        tick();
        checks++;
        if (dataA !== 32'h0 || dataB !== 32'h0) begin
            $display("FAIL rst_prio_after_edge: got A=%h B=%h want 0", dataA, dataB);
            errors++;
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        reg_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addrD = AW'(20 + i);
            dataD = 32'hB0B0_0000 + DW'(i);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            addrB = AW'(20 + i);
            #1;
            checks++;
            if (dataB !== 32'hB0B0_0000 + DW'(i)) begin
                $display("FAIL back_to_back[%0d]: got %h want %h", 20 + i, dataB, 32'hB0B0_0000 + DW'(i));
                errors++;
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 24) == 0);
            reg_write = $urandom_range(0, 1) == 1;
            addrD     = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(0, 31));
            dataD     = $urandom;
            addrA     = ($urandom_range(0, 3) == 0) ? addrD : AW'($urandom_range(0, 31));
            addrB     = AW'($urandom_range(0, 31));
            #1;
            ea = model_read(addrA);
            eb = model_read(addrB);
            checks++;
            if (dataA !== ea || dataB !== eb) begin
                $display("FAIL random_pre[%0d]: got A=%h B=%h want A=%h B=%h", n, dataA, dataB, ea, eb);
                errors++;
            end
            tick();
            ea = model_read(addrA);
            checks++;
            if (dataA !== ea) begin
                $display("FAIL random_post[%0d]: got A=%h want %h", n, dataA, ea);
                errors++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        addrA = '0;
        addrB = '0;
        test_x0_before_reset();
        test_reset();
        test_fill();
        test_reset_clears();
        test_x0_protect();
        test_write_enable();
        test_read_during_write();
        test_reset_priority();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
